shift_scheduler: RTL

SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

---
 rtl/shift_scheduler.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/shift_scheduler.sv
// shift_scheduler: two-requester round-robin job scheduler driving an 8-bit
// rotate engine. Each granted job rotates its operand reps+1 times, emitting
// one registered result per step.
module shift_scheduler (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [2:0] amt0,
    input  logic [2:0] amt1,
    input  logic       lr0,
    input  logic       lr1,
    input  logic [1:0] reps0,
    input  logic [1:0] reps1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic [7:0] y,
    output logic       valid,
    output logic       last,
    output logic       id
);

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned RW = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            owner_q, owner_d;
    logic [DW-1:0]   work_q, work_d;
    logic [AW-1:0]   amt_q, amt_d;
    logic            lr_q, lr_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   y_q, y_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;
    logic            id_q, id_d;

    logic            grant_c;
    logic [DW-1:0]   rot_c;

    // Rotate by doubling the word so the wrapped bits fall into the kept half.
    function automatic logic [DW-1:0] rotate(input logic [DW-1:0] x,
                                             input logic [AW-1:0] n,
                                             input logic          left);
        logic [2*DW-1:0] dbl;
        logic [2*DW-1:0] sh;
        dbl = {x, x};
        if (left) begin
            sh = dbl << n;
            return sh[2*DW-1:DW];
        end else begin
            sh = dbl >> n;
            return sh[DW-1:0];
        end
    endfunction

    // Requester picked when leaving IDLE: sole requester, else the pointer.
    always_comb begin
        grant_c = 1'b0;
        if (req0 && req1) begin
            grant_c = ptr_q;
        end else begin
            grant_c = req1;
        end
    end

    // One rotation step of the working register with the latched settings.
    always_comb begin
        rot_c = rotate(work_q, amt_q, lr_q);
    end

    // State register and all datapath/output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
            work_q  <= '0;
            amt_q   <= '0;
            lr_q    <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            work_q  <= work_d;
            amt_q   <= amt_d;
            lr_q    <= lr_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
            id_q    <= id_d;
        end
    end

    // Next-state and next-output logic: grant in IDLE, rotate once per RUN cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        work_d  = work_q;
        amt_d   = amt_q;
        lr_d    = lr_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        id_d    = id_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant_c;
                    ack0_d  = ~grant_c;
                    ack1_d  = grant_c;
                    if (grant_c) begin
                        work_d = a1;
                        amt_d  = amt1;
                        lr_d   = lr1;
                        cnt_d  = reps1;
                    end else begin
                        work_d = a0;
                        amt_d  = amt0;
                        lr_d   = lr0;
                        cnt_d  = reps0;
                    end
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d  = rot_c;
                y_d     = rot_c;
                id_d    = owner_q;
                valid_d = 1'b1;
                if (cnt_q == RW'(0)) begin
                    last_d  = 1'b1;
                    ptr_d   = ~owner_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - RW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
    end

    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;
    assign y     = y_q;
    assign valid = valid_q;
    assign last  = last_q;
    assign id    = id_q;

endmodule
